// File: rtl/vc_pkg.sv
// Shared constants, FSM encoding and helpers for the VC flag tracker and its counters.
package vc_pkg;

   localparam int NUM_VC   = 8;
   localparam int VC_IDX_W = 3;
   localparam int CNT_W    = 3;

   typedef enum logic {
      IDLE  = 1'b0,
      SERVE = 1'b1
   } state_t;

   // True when exactly one bit is set; all-zero is not one-hot.
   function automatic logic is_onehot(input logic [NUM_VC-1:0] v);
      logic [NUM_VC-1:0] one;
      one = {{(NUM_VC-1){1'b0}}, 1'b1};
      return (v != '0) && ((v & (v - one)) == '0);
   endfunction

endpackage

// File: rtl/vc_pkt_counter.sv
// Saturating up/down count of complete packets held in one VC buffer.
module vc_pkt_counter
   import vc_pkg::*;
#(
   parameter int CW = vc_pkg::CNT_W
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          inc,
   input  logic          dec,
   output logic [CW-1:0] cnt,
   output logic          nonzero,
   output logic          ovf
);

   localparam logic [CW-1:0] CNT_MAX = '1;
   localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

   logic [CW-1:0] cnt_reg;
   logic [CW-1:0] cnt_next;
   logic          ovf_next;

   // A simultaneous arrival and drain cancel out, even at saturation.
   always_comb begin
      cnt_next = cnt_reg;
      ovf_next = 1'b0;
      if (inc && !dec) begin
         if (cnt_reg == CNT_MAX) begin
            ovf_next = 1'b1;
         end else begin
            cnt_next = cnt_reg + CNT_ONE;
         end
      end else if (dec && !inc && (cnt_reg != '0)) begin
         cnt_next = cnt_reg - CNT_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_next;
      end
   end

   assign cnt     = cnt_reg;
   assign nonzero = (cnt_next != '0);
   assign ovf     = ovf_next;

endmodule

// File: rtl/vc_flag_tracker.sv
// Per-VC packet-pending flags for the cleaner, plus a grant lock held until one packet drains.
module vc_flag_tracker
   import vc_pkg::*;
#(
   parameter int NUM_VC   = vc_pkg::NUM_VC,
   parameter int VC_IDX_W = vc_pkg::VC_IDX_W,
   parameter int CNT_W    = vc_pkg::CNT_W
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   input  logic [VC_IDX_W-1:0] in_vc,
   input  logic                in_tail,
   output logic [NUM_VC-1:0]   vc_flags,
   input  logic [NUM_VC-1:0]   vc_sel,
   output logic [NUM_VC-1:0]   vc_grant,
   output logic                grant_valid,
   input  logic                srv_valid,
   input  logic                srv_tail,
   output logic                ovf_err,
   output logic                proto_err
);

   state_t            state_reg;
   state_t            state_next;
   logic [NUM_VC-1:0] grant_reg;
   logic [NUM_VC-1:0] grant_next;
   logic [NUM_VC-1:0] flags_reg;
   logic              gv_reg;
   logic              ovf_err_reg;
   logic              proto_err_reg;
   logic              proto_set;
   logic              serve_pop;

   logic [NUM_VC-1:0] inc_vec;
   logic [NUM_VC-1:0] dec_vec;
   logic [NUM_VC-1:0] nz_vec;
   logic [NUM_VC-1:0] ovf_vec;
   logic [CNT_W-1:0]  cnt_arr [NUM_VC];

   assign serve_pop = (state_reg == SERVE) && srv_valid && srv_tail;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_VC; gi++) begin : g_vc
         assign inc_vec[gi] = in_valid && in_tail && (in_vc == VC_IDX_W'(gi));
         // The count guard keeps an empty VC from ever underflowing.
         assign dec_vec[gi] = serve_pop && grant_reg[gi] && (cnt_arr[gi] != '0);

         vc_pkt_counter #(
            .CW (CNT_W)
         ) u_cnt (
            .clk     (clk),
            .rst     (rst),
            .inc     (inc_vec[gi]),
            .dec     (dec_vec[gi]),
            .cnt     (cnt_arr[gi]),
            .nonzero (nz_vec[gi]),
            .ovf     (ovf_vec[gi])
         );
      end
   endgenerate

   always_comb begin
      state_next = state_reg;
      grant_next = grant_reg;
      proto_set  = 1'b0;
      case (state_reg)
         IDLE: begin
            grant_next = '0;
            if (srv_valid) begin
               proto_set = 1'b1;
            end
            if (vc_sel != '0) begin
               if (is_onehot(vc_sel) && ((vc_sel & flags_reg) != '0)) begin
                  grant_next = vc_sel;
                  state_next = SERVE;
               end else begin
                  proto_set = 1'b1;
               end
            end
         end
         SERVE: begin
            // Grant drops on the tail edge, forcing one idle cycle before re-arbitration.
            if (srv_valid && srv_tail) begin
               grant_next = '0;
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
            grant_next = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         grant_reg     <= '0;
         gv_reg        <= 1'b0;
         flags_reg     <= '0;
         ovf_err_reg   <= 1'b0;
         proto_err_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         grant_reg     <= grant_next;
         gv_reg        <= |grant_next;
         flags_reg     <= nz_vec;
         ovf_err_reg   <= ovf_err_reg | (|ovf_vec);
         proto_err_reg <= proto_err_reg | proto_set;
      end
   end

   assign vc_flags    = flags_reg;
   assign vc_grant    = grant_reg;
   assign grant_valid = gv_reg;
   assign ovf_err     = ovf_err_reg;
   assign proto_err   = proto_err_reg;

endmodule

// File: tb/tb_vc_flag_tracker.sv
// Directed bench: stimulus queues expected outputs per cycle, a monitor pops and compares them.
module tb_vc_flag_tracker;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [2:0] in_vc;
   logic       in_tail;
   logic [7:0] vc_flags;
   logic [7:0] vc_sel;
   logic [7:0] vc_grant;
   logic       grant_valid;
   logic       srv_valid;
   logic       srv_tail;
   logic       ovf_err;
   logic       proto_err;

   logic       sel_ovr;
   logic [7:0] sel_force;

   always #5 clk = ~clk;

   // Cleaner model: lowest-index set flag, unless a test forces a raw selection.
   always_comb vc_sel = sel_ovr ? sel_force : (vc_flags & (~vc_flags + 8'd1));

   vc_flag_tracker dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_vc       (in_vc),
      .in_tail     (in_tail),
      .vc_flags    (vc_flags),
      .vc_sel      (vc_sel),
      .vc_grant    (vc_grant),
      .grant_valid (grant_valid),
      .srv_valid   (srv_valid),
      .srv_tail    (srv_tail),
      .ovf_err     (ovf_err),
      .proto_err   (proto_err)
   );

   typedef struct packed {
      logic [7:0] flags;
      logic [7:0] grant;
      logic       gv;
      logic       ovf;
      logic       proto;
   } obs_t;

   obs_t  exp_q[$];
   string tag_q[$];
   int    n_cmp = 0;
   int    n_bad = 0;

   task automatic cyc(input string tag, input logic r, input logic iv, input logic [2:0] ivc,
                      input logic it, input logic sv, input logic st,
                      input logic [7:0] ef, input logic [7:0] eg, input logic eo, input logic ep);
      obs_t e;
      rst       = r;
      in_valid  = iv;
      in_vc     = ivc;
      in_tail   = it;
      srv_valid = sv;
      srv_tail  = st;
      e.flags = ef;
      e.grant = eg;
      e.gv    = |eg;
      e.ovf   = eo;
      e.proto = ep;
      exp_q.push_back(e);
      tag_q.push_back(tag);
      @(posedge clk);
      #1;
   endtask

   task automatic quiet(input string tag, input logic [7:0] ef, input logic [7:0] eg,
                        input logic eo, input logic ep);
      cyc(tag, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, ef, eg, eo, ep);
   endtask

   task automatic do_rst(input string tag);
      cyc(tag, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (exp_q.size() != 0) begin
            obs_t  e;
            obs_t  a;
            string t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            a = {vc_flags, vc_grant, grant_valid, ovf_err, proto_err};
            n_cmp++;
            if (a !== e) begin
               n_bad++;
               $display("FAIL %s: got flags=%h grant=%h gv=%b ovf=%b proto=%b, need flags=%h grant=%h gv=%b ovf=%b proto=%b",
                        t, a.flags, a.grant, a.gv, a.ovf, a.proto, e.flags, e.grant, e.gv, e.ovf, e.proto);
            end else begin
               $display("ok   %s: flags=%h grant=%h gv=%b ovf=%b proto=%b",
                        t, a.flags, a.grant, a.gv, a.ovf, a.proto);
            end
         end
      end
   end

   initial begin
      sel_ovr   = 1'b0;
      sel_force = 8'h00;

      // Reset then idle
      do_rst("reset0");
      do_rst("reset1");
      for (int i = 0; i < 5; i++) quiet("idle", 8'h00, 8'h00, 1'b0, 1'b0);

      // Single packet on VC5, three flits served
      cyc("vc5_tail", 0, 1, 3'd5, 1, 0, 0, 8'h20, 8'h00, 0, 0);
      quiet("vc5_grant", 8'h20, 8'h20, 0, 0);
      cyc("vc5_flit0", 0, 0, 3'd0, 0, 1, 0, 8'h20, 8'h20, 0, 0);
      cyc("vc5_flit1", 0, 0, 3'd0, 0, 1, 0, 8'h20, 8'h20, 0, 0);
      cyc("vc5_srvtail", 0, 0, 3'd0, 0, 1, 1, 8'h00, 8'h00, 0, 0);
      quiet("vc5_after", 8'h00, 8'h00, 0, 0);

      // Priority: VC1 arrives while VC6 is locked
      cyc("vc6_tail", 0, 1, 3'd6, 1, 0, 0, 8'h40, 8'h00, 0, 0);
      quiet("vc6_grant", 8'h40, 8'h40, 0, 0);
      cyc("vc1_tail", 0, 1, 3'd1, 1, 0, 0, 8'h42, 8'h40, 0, 0);
      cyc("vc6_flit", 0, 0, 3'd0, 0, 1, 0, 8'h42, 8'h40, 0, 0);
      cyc("vc6_srvtail", 0, 0, 3'd0, 0, 1, 1, 8'h02, 8'h00, 0, 0);
      quiet("vc1_grant", 8'h02, 8'h02, 0, 0);
      cyc("vc1_srvtail", 0, 0, 3'd0, 0, 1, 1, 8'h00, 8'h00, 0, 0);
      quiet("rearb_after", 8'h00, 8'h00, 0, 0);

      // Simultaneous arrival and drain on VC2
      cyc("vc2_tail", 0, 1, 3'd2, 1, 0, 0, 8'h04, 8'h00, 0, 0);
      quiet("vc2_grant", 8'h04, 8'h04, 0, 0);
      cyc("vc2_incdec", 0, 1, 3'd2, 1, 1, 1, 8'h04, 8'h00, 0, 0);
      quiet("vc2_regrant", 8'h04, 8'h04, 0, 0);
      cyc("vc2_srvtail", 0, 0, 3'd0, 0, 1, 1, 8'h00, 8'h00, 0, 0);
      quiet("vc2_after", 8'h00, 8'h00, 0, 0);

      // Saturation on VC0: eight tails, then seven packets drained
      for (int k = 1; k <= 8; k++)
         cyc("sat_tail", 0, 1, 3'd0, 1, 0, 0, 8'h01, (k >= 2) ? 8'h01 : 8'h00, (k == 8), 0);
      for (int k = 1; k <= 7; k++) begin
         cyc("sat_srvtail", 0, 0, 3'd0, 0, 1, 1, (k < 7) ? 8'h01 : 8'h00, 8'h00, 1, 0);
         quiet("sat_regrant", (k < 7) ? 8'h01 : 8'h00, (k < 7) ? 8'h01 : 8'h00, 1, 0);
      end
      do_rst("sat_rst");

      // Protocol errors in IDLE
      cyc("idle_srv", 0, 0, 3'd0, 0, 1, 1, 8'h00, 8'h00, 0, 1);
      do_rst("pe_rst0");
      sel_ovr   = 1'b1;
      sel_force = 8'h03;
      quiet("sel_multi", 8'h00, 8'h00, 0, 1);
      sel_ovr = 1'b0;
      do_rst("pe_rst1");
      sel_ovr   = 1'b1;
      sel_force = 8'h10;
      quiet("sel_uncovered", 8'h00, 8'h00, 0, 1);
      sel_ovr = 1'b0;
      do_rst("pe_rst2");

      // Reset in the middle of serving VC3 with an error flag already set
      cyc("mid_pe", 0, 0, 3'd0, 0, 1, 0, 8'h00, 8'h00, 0, 1);
      cyc("mid_tail", 0, 1, 3'd3, 1, 0, 0, 8'h08, 8'h00, 0, 1);
      quiet("mid_grant", 8'h08, 8'h08, 0, 1);
      cyc("mid_flit", 0, 0, 3'd0, 0, 1, 0, 8'h08, 8'h08, 0, 1);
      do_rst("mid_rst");
      quiet("mid_after", 8'h00, 8'h00, 0, 0);
      quiet("mid_after2", 8'h00, 8'h00, 0, 0);

      for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain: %0d expectations left unchecked, need 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
